// File: rtl/data_sram_bridge_pkg.sv
// Shared types and constants for the data-side SRAM-like bus bridge.
package data_sram_bridge_pkg;

  localparam int unsigned SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/data_sram_bridge_sel_to_size.sv
// Byte-enable to bus transfer size decoder; shared with the instruction-side bridge.
module data_sram_bridge_sel_to_size
  import data_sram_bridge_pkg::*;
(
  input  logic [SEL_W-1:0] select_i,
  output logic [1:0]       size_o
);

  // Unsupported lane patterns fall back to word size.
  always_comb begin
    size_o = SIZE_W;
    case (select_i)
      4'b1111:                            size_o = SIZE_W;
      4'b0011, 4'b1100:                   size_o = SIZE_H;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size_o = SIZE_B;
      default:                            size_o = SIZE_W;
    endcase
  end

endmodule

// File: rtl/data_sram_bridge.sv
// Memory-stage to SRAM-like bus bridge: one outstanding transaction, pipeline
// stall until completion, load data held until the memory stage advances.
module data_sram_bridge
  import data_sram_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memreadM,
  input  logic              memwriteM,
  input  logic [ADDR_W-1:0] aluoutM,
  input  logic [DATA_W-1:0] writedataM,
  input  logic [SEL_W-1:0]  selectM,
  input  logic              flushM,
  input  logic              advanceM,
  output logic [DATA_W-1:0] readdataM,
  output logic              mem_stall,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  state_e              state_q, state_d;
  logic                discard_q, discard_d;
  logic                wr_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                access_c;
  logic                drop_c;
  logic                cur_wr_c;
  logic [1:0]          sel_size_c;

  assign access_c = (memreadM | memwriteM) & ~flushM;
  // A flush arriving in the completion cycle must also drop the result.
  assign drop_c   = discard_q | flushM;
  assign cur_wr_c = (state_q == IDLE) ? memwriteM : wr_q;

  data_sram_bridge_sel_to_size u_sel_to_size (
    .select_i (selectM),
    .size_o   (sel_size_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (access_c) begin
          if (data_addr_ok && data_data_ok) state_d = DONE;
          else if (data_addr_ok)            state_d = WAIT;
          else                              state_d = REQ;
        end
      end
      REQ: begin
        if (data_addr_ok) begin
          if (data_data_ok) state_d = drop_c ? IDLE : DONE;
          else              state_d = WAIT;
        end
      end
      WAIT: begin
        if (data_data_ok) state_d = drop_c ? IDLE : DONE;
      end
      DONE: begin
        if (advanceM || flushM) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // IDLE presents the live request; later states replay the latched fields.
  always_comb begin
    data_req   = 1'b0;
    mem_stall  = 1'b0;
    data_wr    = wr_q;
    data_size  = size_q;
    data_addr  = addr_q;
    data_wdata = wdata_q;
    case (state_q)
      IDLE: begin
        data_req   = access_c;
        mem_stall  = access_c;
        data_wr    = memwriteM;
        data_size  = sel_size_c;
        data_addr  = aluoutM;
        data_wdata = writedataM;
      end
      REQ: begin
        data_req  = 1'b1;
        mem_stall = ~discard_q;
      end
      WAIT: begin
        mem_stall = ~discard_q;
      end
      DONE: begin
        mem_stall = 1'b0;
      end
      default: begin
        mem_stall = 1'b0;
      end
    endcase
    if (rst) begin
      data_req  = 1'b0;
      mem_stall = 1'b0;
    end
  end

  assign discard_d = (state_d == IDLE) ? 1'b0 :
                     (((state_q == REQ) || (state_q == WAIT)) && flushM) ? 1'b1 :
                     discard_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      discard_q <= 1'b0;
      wr_q      <= 1'b0;
      size_q    <= SIZE_W;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      discard_q <= discard_d;
      if ((state_q == IDLE) && access_c) begin
        wr_q    <= memwriteM;
        size_q  <= sel_size_c;
        addr_q  <= aluoutM;
        wdata_q <= writedataM;
      end
      if ((state_d == DONE) && (state_q != DONE) && !cur_wr_c) begin
        rdata_q <= data_rdata;
      end
    end
  end

  assign readdataM = rdata_q;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed bench for data_sram_bridge: size-decode vector table plus
// hand-written bus handshake sequences.
module tb_data_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        memreadM, memwriteM, flushM, advanceM;
  logic [31:0] aluoutM, writedataM, readdataM;
  logic [3:0]  selectM;
  logic        mem_stall, data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_sram_bridge dut (
    .clk          (clk),
    .rst          (rst),
    .memreadM     (memreadM),
    .memwriteM    (memwriteM),
    .aluoutM      (aluoutM),
    .writedataM   (writedataM),
    .selectM      (selectM),
    .flushM       (flushM),
    .advanceM     (advanceM),
    .readdataM    (readdataM),
    .mem_stall    (mem_stall),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata)
  );

  typedef struct {
    logic       rd;
    logic       wr;
    logic       fl;
    logic [3:0] sel;
    logic       req;
    logic [1:0] size;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(input logic rd, input logic wr, input logic fl,
                              input logic [3:0] sel, input logic req, input logic [1:0] size);
    vec_t v;
    v.rd = rd; v.wr = wr; v.fl = fl; v.sel = sel; v.req = req; v.size = size;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk_rs(input string nm, input logic req, input logic stall);
    chk({nm, ".req"}, 32'(data_req), 32'(req));
    chk({nm, ".stall"}, 32'(mem_stall), 32'(stall));
  endtask

  initial begin
    vecs[0] = mk(1'b1, 1'b0, 1'b0, 4'b1111, 1'b1, 2'd2);
    vecs[1] = mk(1'b0, 1'b1, 1'b0, 4'b0011, 1'b1, 2'd1);
    vecs[2] = mk(1'b1, 1'b0, 1'b0, 4'b1100, 1'b1, 2'd1);
    vecs[3] = mk(1'b0, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0);
    vecs[4] = mk(1'b1, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd0);
    vecs[5] = mk(1'b1, 1'b0, 1'b0, 4'b0110, 1'b1, 2'd2);
    vecs[6] = mk(1'b1, 1'b0, 1'b1, 4'b1111, 1'b0, 2'd2);
    vecs[7] = mk(1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 2'd0);

    rst = 1'b1; memreadM = 1'b1; memwriteM = 1'b0; flushM = 1'b0; advanceM = 1'b0;
    aluoutM = '0; writedataM = '0; selectM = 4'hF;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;

    // Reset state, with a live access present to show it is masked.
    cyc(); cyc(); settle();
    chk_rs("reset", 1'b0, 1'b0);
    chk("reset.rdata", readdataM, 32'h0);
    cyc(); rst = 1'b0; memreadM = 1'b0;

    // Size decode table, applied in IDLE and withdrawn before the clock edge.
    for (int i = 0; i < 8; i++) begin
      cyc();
      memreadM = vecs[i].rd; memwriteM = vecs[i].wr; flushM = vecs[i].fl;
      selectM = vecs[i].sel; aluoutM = 32'h0000_0100 + 32'(i * 4);
      settle();
      chk_rs($sformatf("vec%0d", i), vecs[i].req, vecs[i].req);
      chk($sformatf("vec%0d.size", i), 32'(data_size), 32'(vecs[i].size));
      chk($sformatf("vec%0d.addr", i), data_addr, 32'h0000_0100 + 32'(i * 4));
      chk($sformatf("vec%0d.wr", i), 32'(data_wr), 32'(vecs[i].wr));
      memreadM = 1'b0; memwriteM = 1'b0; flushM = 1'b0;
    end

    // Load word, zero-wait slave.
    cyc();
    memreadM = 1'b1; aluoutM = 32'h1000_0004; selectM = 4'hF; data_addr_ok = 1'b1;
    settle();
    chk_rs("lw.c0", 1'b1, 1'b1);
    chk("lw.c0.size", 32'(data_size), 32'd2);
    chk("lw.c0.addr", data_addr, 32'h1000_0004);
    chk("lw.c0.wr", 32'(data_wr), 32'd0);
    cyc(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
    settle(); chk_rs("lw.c1", 1'b0, 1'b1);
    cyc(); data_data_ok = 1'b0; data_rdata = '0;
    settle(); chk_rs("lw.c2", 1'b0, 1'b0);
    chk("lw.c2.rdata", readdataM, 32'hDEAD_BEEF);

    // DONE held without advance; a stray data_ok must be ignored.
    for (int i = 0; i < 3; i++) begin
      cyc();
      data_data_ok = (i == 1);
      data_rdata   = (i == 1) ? 32'h1111_1111 : 32'h0;
      settle();
      chk_rs($sformatf("hold%0d", i), 1'b0, 1'b0);
      chk($sformatf("hold%0d.rdata", i), readdataM, 32'hDEAD_BEEF);
    end
    cyc(); advanceM = 1'b1; data_data_ok = 1'b0;
    settle(); chk_rs("hold.adv", 1'b0, 1'b0);

    // Back-to-back load with addr_ok and data_ok together in IDLE.
    cyc(); advanceM = 1'b0; aluoutM = 32'h1000_0008;
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
    settle(); chk_rs("b2b.c0", 1'b1, 1'b1);
    chk("b2b.c0.addr", data_addr, 32'h1000_0008);
    cyc(); data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    settle(); chk_rs("b2b.c1", 1'b0, 1'b0);
    chk("b2b.c1.rdata", readdataM, 32'h1234_5678);
    cyc(); advanceM = 1'b1;
    cyc(); advanceM = 1'b0; memreadM = 1'b0;

    // Store byte, slow slave; core inputs scrambled to prove the fields are latched.
    for (int k = 0; k < 7; k++) begin
      cyc();
      memwriteM = 1'b1;
      if (k == 0) begin
        selectM = 4'b0100; writedataM = 32'h00AB_0000; aluoutM = 32'h0000_0102;
      end else begin
        selectM = 4'hF; writedataM = 32'h0; aluoutM = 32'hFFFF_FFF0;
      end
      data_addr_ok = (k == 3);
      data_data_ok = (k == 5);
      data_rdata   = (k == 5) ? 32'h5555_5555 : 32'h0;
      settle();
      chk_rs($sformatf("sb.c%0d", k), (k < 4), (k < 6));
      if (k < 4) begin
        chk($sformatf("sb.c%0d.wr", k), 32'(data_wr), 32'd1);
        chk($sformatf("sb.c%0d.size", k), 32'(data_size), 32'd0);
        chk($sformatf("sb.c%0d.addr", k), data_addr, 32'h0000_0102);
        chk($sformatf("sb.c%0d.wdata", k), data_wdata, 32'h00AB_0000);
      end
    end
    chk("sb.rdata", readdataM, 32'h1234_5678);
    cyc(); advanceM = 1'b1; memwriteM = 1'b0;
    cyc(); advanceM = 1'b0;

    // Flush during WAIT: stall drops, completion discarded.
    cyc(); memreadM = 1'b1; aluoutM = 32'h2000_0000; selectM = 4'hF; data_addr_ok = 1'b1;
    settle(); chk_rs("fw.c0", 1'b1, 1'b1);
    cyc(); data_addr_ok = 1'b0; flushM = 1'b1;
    settle(); chk_rs("fw.c1", 1'b0, 1'b1);
    cyc(); flushM = 1'b0; memreadM = 1'b0;
    settle(); chk_rs("fw.c2", 1'b0, 1'b0);
    cyc(); data_data_ok = 1'b1; data_rdata = 32'hBAD0_BAD0;
    settle(); chk_rs("fw.c3", 1'b0, 1'b0);

    // Back in IDLE: new load that stalls in REQ, then flushed there.
    cyc(); data_data_ok = 1'b0; data_rdata = '0; memreadM = 1'b1; aluoutM = 32'h2000_0010;
    settle(); chk_rs("fr.c0", 1'b1, 1'b1);
    chk("fw.rdata", readdataM, 32'h1234_5678);
    cyc(); flushM = 1'b1; memreadM = 1'b0; aluoutM = '0;
    settle(); chk_rs("fr.c1", 1'b1, 1'b1);
    chk("fr.c1.addr", data_addr, 32'h2000_0010);
    cyc(); flushM = 1'b0;
    settle(); chk_rs("fr.c2", 1'b1, 1'b0);
    cyc();
    settle(); chk_rs("fr.c3", 1'b1, 1'b0);
    cyc(); data_addr_ok = 1'b1;
    settle(); chk_rs("fr.c4", 1'b1, 1'b0);
    cyc(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
    settle(); chk_rs("fr.c5", 1'b0, 1'b0);

    // Discarded result must not land, and the FSM must be in IDLE again.
    cyc(); memreadM = 1'b1; aluoutM = 32'h2000_0020;
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h0BAD_F00D;
    settle(); chk_rs("fr.c6", 1'b1, 1'b1);
    chk("fr.c6.rdata", readdataM, 32'h1234_5678);
    cyc(); memreadM = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    settle(); chk_rs("fr.c7", 1'b0, 1'b0);
    chk("fr.c7.rdata", readdataM, 32'h0BAD_F00D);
    cyc(); advanceM = 1'b1;
    cyc(); advanceM = 1'b0;

    // Reset in the middle of a pending request.
    cyc(); memreadM = 1'b1; aluoutM = 32'h3000_0000;
    settle(); chk_rs("rst.c0", 1'b1, 1'b1);
    cyc(); rst = 1'b1; memreadM = 1'b0;
    settle(); chk_rs("rst.c1", 1'b0, 1'b0);
    cyc(); rst = 1'b0;
    settle(); chk_rs("rst.c2", 1'b0, 1'b0);
    chk("rst.c2.rdata", readdataM, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
